// File: rtl/axi_ram_rd_arbiter.sv
// Two-port round-robin read arbiter in front of a single AXI RAM read channel.
// One burst is outstanding at a time; R beats are steered to the port that owns it.
module axi_ram_rd_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int ID_WIDTH   = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic [2*ID_WIDTH-1:0]   s_axi_arid,
    input  logic [2*ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [2*LEN_WIDTH-1:0]  s_axi_arlen,
    input  logic [2*3-1:0]          s_axi_arsize,
    input  logic [2*2-1:0]          s_axi_arburst,
    input  logic [1:0]              s_axi_arvalid,
    output logic [1:0]              s_axi_arready,
    output logic [2*ID_WIDTH-1:0]   s_axi_rid,
    output logic [2*DATA_WIDTH-1:0] s_axi_rdata,
    output logic [2*2-1:0]          s_axi_rresp,
    output logic [1:0]              s_axi_rlast,
    output logic [1:0]              s_axi_rvalid,
    input  logic [1:0]              s_axi_rready,

    output logic [ID_WIDTH-1:0]     m_axi_arid,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [LEN_WIDTH-1:0]    m_axi_arlen,
    output logic [2:0]              m_axi_arsize,
    output logic [1:0]              m_axi_arburst,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [ID_WIDTH-1:0]     m_axi_rid,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rlast,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
);
    localparam int NPORTS = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    grant_q, grant_d;
    logic                    last_grant_q, last_grant_d;
    logic                    sel;
    logic [ID_WIDTH-1:0]     arid_q, arid_d;
    logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
    logic [LEN_WIDTH-1:0]    arlen_q, arlen_d;
    logic [2:0]              arsize_q, arsize_d;
    logic [1:0]              arburst_q, arburst_d;
    logic                    arvalid_q, arvalid_d;

    logic [ID_WIDTH-1:0]     port_arid    [NPORTS];
    logic [ADDR_WIDTH-1:0]   port_araddr  [NPORTS];
    logic [LEN_WIDTH-1:0]    port_arlen   [NPORTS];
    logic [2:0]              port_arsize  [NPORTS];
    logic [1:0]              port_arburst [NPORTS];

    // Unpack the per-port AR fields and fan the R payload out to both slots.
    generate
        for (genvar gi = 0; gi < NPORTS; gi++) begin : g_port
            assign port_arid[gi]    = s_axi_arid[gi*ID_WIDTH +: ID_WIDTH];
            assign port_araddr[gi]  = s_axi_araddr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign port_arlen[gi]   = s_axi_arlen[gi*LEN_WIDTH +: LEN_WIDTH];
            assign port_arsize[gi]  = s_axi_arsize[gi*3 +: 3];
            assign port_arburst[gi] = s_axi_arburst[gi*2 +: 2];

            assign s_axi_rid[gi*ID_WIDTH +: ID_WIDTH]       = m_axi_rid;
            assign s_axi_rdata[gi*DATA_WIDTH +: DATA_WIDTH] = m_axi_rdata;
            assign s_axi_rresp[gi*2 +: 2]                   = m_axi_rresp;
            assign s_axi_rlast[gi]                          = m_axi_rlast;
        end
    endgenerate

    assign m_axi_arid    = arid_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = arlen_q;
    assign m_axi_arsize  = arsize_q;
    assign m_axi_arburst = arburst_q;
    assign m_axi_arvalid = arvalid_q;

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        arid_d        = arid_q;
        araddr_d      = araddr_q;
        arlen_d       = arlen_q;
        arsize_d      = arsize_q;
        arburst_d     = arburst_q;
        arvalid_d     = arvalid_q;
        s_axi_arready = '0;
        s_axi_rvalid  = '0;
        m_axi_rready  = 1'b0;
        // On a tie the port that did not win last time goes next.
        sel = (&s_axi_arvalid) ? ~last_grant_q : s_axi_arvalid[1];

        // Handshake outputs stay quiet while reset is held, even in IDLE.
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (|s_axi_arvalid) begin
                        s_axi_arready[sel] = 1'b1;
                        arid_d    = port_arid[sel];
                        araddr_d  = port_araddr[sel];
                        arlen_d   = port_arlen[sel];
                        arsize_d  = port_arsize[sel];
                        arburst_d = port_arburst[sel];
                        arvalid_d = 1'b1;
                        grant_d   = sel;
                        state_d   = ADDR;
                    end
                end
                ADDR: begin
                    if (m_axi_arready) begin
                        arvalid_d = 1'b0;
                        state_d   = DATA;
                    end
                end
                DATA: begin
                    s_axi_rvalid[grant_q] = m_axi_rvalid;
                    m_axi_rready          = s_axi_rready[grant_q];
                    if (m_axi_rvalid && s_axi_rready[grant_q] && m_axi_rlast) begin
                        last_grant_d = grant_q;
                        state_d      = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            arid_q       <= '0;
            araddr_q     <= '0;
            arlen_q      <= '0;
            arsize_q     <= '0;
            arburst_q    <= '0;
            arvalid_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            arid_q       <= arid_d;
            araddr_q     <= araddr_d;
            arlen_q      <= arlen_d;
            arsize_q     <= arsize_d;
            arburst_q    <= arburst_d;
            arvalid_q    <= arvalid_d;
        end
    end

endmodule

// File: doc/axi_ram_rd_arbiter.md
AXI_RAM_RD_ARBITER -- requirements
Module: axi_ram_rd_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, R data width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, AR address width in bits.
REQ-003 SHALL have parameter ID_WIDTH, default 8, AR/R ID width in bits.
REQ-004 SHALL have parameter LEN_WIDTH, default 8, burst length field width in bits.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 s_axi_arid  input  2*ID_WIDTH  requester ARID, port i at bits [i*ID_WIDTH +: ID_WIDTH].
REQ-008 s_axi_araddr  input  2*ADDR_WIDTH  requester ARADDR, packed the same way.
REQ-009 s_axi_arlen  input  2*LEN_WIDTH  requester ARLEN.
REQ-010 s_axi_arsize  input  2*3  requester ARSIZE.
REQ-011 s_axi_arburst  input  2*2  requester ARBURST.
REQ-012 s_axi_arvalid  input  2  requester ARVALID, one bit per port.
REQ-013 s_axi_arready  output  2  requester ARREADY.
REQ-014 s_axi_rid  output  2*ID_WIDTH  RID, m_axi_rid copied to both slots.
REQ-015 s_axi_rdata  output  2*DATA_WIDTH  RDATA, m_axi_rdata copied to both slots.
REQ-016 s_axi_rresp  output  2*2  RRESP, copied to both slots.
REQ-017 s_axi_rlast  output  2  RLAST, copied to both bits.
REQ-018 s_axi_rvalid  output  2  RVALID, asserted only on the granted port.
REQ-019 s_axi_rready  input  2  requester RREADY.
REQ-020 m_axi_arid  output  ID_WIDTH  registered ARID to the RAM.
REQ-021 m_axi_araddr  output  ADDR_WIDTH  registered ARADDR.
REQ-022 m_axi_arlen  output  LEN_WIDTH  registered ARLEN.
REQ-023 m_axi_arsize  output  3  registered ARSIZE.
REQ-024 m_axi_arburst  output  2  registered ARBURST.
REQ-025 m_axi_arvalid  output  1  registered ARVALID.
REQ-026 m_axi_arready  input  1  RAM ARREADY.
REQ-027 m_axi_rid  input  ID_WIDTH  RAM RID.
REQ-028 m_axi_rdata  input  DATA_WIDTH  RAM RDATA.
REQ-029 m_axi_rresp  input  2  RAM RRESP.
REQ-030 m_axi_rlast  input  1  RAM RLAST.
REQ-031 m_axi_rvalid  input  1  RAM RVALID.
REQ-032 m_axi_rready  output  1  RAM RREADY.

Function
REQ-033 SHALL implement FSM with states IDLE, ADDR, DATA and keep exactly one burst outstanding to the RAM.
REQ-034 IDLE: on any s_axi_arvalid, select port g round-robin; if both ports request, g = port not granted last.
REQ-035 IDLE accept: s_axi_arready[g] = 1 combinationally in that cycle only; capture AR fields into m_axi_ar* registers and store g; set m_axi_arvalid = 1 at next edge; next state ADDR; AR latency is 1 cycle.
REQ-036 ADDR: hold m_axi_ar* and m_axi_arvalid stable until m_axi_arready = 1; then drop m_axi_arvalid and go to DATA.
REQ-037 DATA: s_axi_rvalid[g] = m_axi_rvalid and m_axi_rready = s_axi_rready[g], both combinational; the other port's rvalid = 0; data, ID, resp and last pass through with zero latency.
REQ-038 DATA: on m_axi_rvalid && m_axi_rready && m_axi_rlast, set last_grant = g and return to IDLE; the next AR can be accepted in the following cycle.
REQ-039 s_axi_arready SHALL be 0 for both ports outside IDLE, and for the non-selected port in IDLE.
REQ-040 m_axi_rready SHALL be 0 in IDLE and ADDR; stray RAM R beats SHALL stall and never reach a requester.
REQ-041 A requester that deasserts arvalid before acceptance SHALL lose arbitration without side effects.
REQ-042 ARLEN = 0 SHALL work: a single beat with rlast = 1 completes DATA.

Reset
REQ-043 While rst = 1: state IDLE, m_axi_arvalid 0, m_axi_rready 0, s_axi_arready 00, s_axi_rvalid 00, last_grant = 1 (port 0 wins first tie), m_axi_ar* fields cleared to 0.
REQ-044 Reset mid-ADDR or mid-DATA SHALL abandon the burst; after reset, no further beats are forwarded to either port.

Verification
REQ-045 Single request: port 0 AR (id 0x12, addr 0x0100, len 3, incr), RAM always ready -> m_axi_arvalid 1 cycle after accept, 4 beats reach port 0 only, last beat has rlast = 1, then IDLE.
REQ-046 Simultaneous requests after reset, len 0 each -> port 0 served first, then port 1; with both ports held valid, grants alternate 0,1,0,1.
REQ-047 Backpressure: m_axi_arready low for 5 cycles, s_axi_rready toggling -> AR fields stable while waiting, no beat lost or duplicated, m_axi_rready mirrors the granted rready.
REQ-048 Port 1 arvalid raised during port 0 DATA -> s_axi_arready[1] stays 0 until the cycle after port 0 rlast handshake.
REQ-049 rst asserted mid-burst (beat 2 of 4) -> all outputs at reset values next cycle; a fresh port 1 request is then served normally.
